// File: rtl/arithmetic_unit_serial.sv
// arithmetic_unit_serial
// ----------------------
// Bit-serial (slice-serial) add/subtract-family unit. It pushes DATA_W-bit
// operands through one SLICE_W-bit adder, least-significant slice first,
// one slice per clock.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake; in_ready is high only in IDLE
//   op_code, a_in,     operation and operands, sampled at accept
//   b_in, carry_in
//   out_valid/out_ready  result handshake; the result is held until accepted
//   result_out         DATA_W-bit result
//   carry_out, overflow, zero, negative   flags, valid with out_valid
//
// Op map (A' + B' + Cin):
//   000 PASS a+0+0     001 ADD a+b+0      010 ADC a+b+ci    011 SUB a+~b+1
//   100 SBB a+~b+ci    101 INC a+0+1      110 DEC a+1s+0    111 NEG 0+~b+1
module arithmetic_unit_serial #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result_out,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SBB  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_NEG  = 3'b111;

  // A width that does not split into whole slices cannot be processed.
  generate
    if ((DATA_W % SLICE_W) != 0) begin : g_bad_width
      $error("arithmetic_unit_serial: DATA_W must be a multiple of SLICE_W");
    end
  endgenerate

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] a_sh_r;
  logic [DATA_W-1:0] b_sh_r;
  logic              carry_r;
  logic              any_nz_r;
  logic [DATA_W-1:0] result_r;
  logic              carry_out_r;
  logic              overflow_r;
  logic              zero_r;
  logic              negative_r;

  logic [DATA_W-1:0] a_sel_s;
  logic [DATA_W-1:0] b_sel_s;
  logic              cin_sel_s;
  logic [SLICE_W:0]  slice_sum_s;
  logic [DATA_W-1:0] slice_ext_s;
  logic [DATA_W-1:0] result_next_s;
  logic              last_slice_s;

  // Operand conditioning: map op_code onto the A' + B' + Cin form.
  always_comb begin
    a_sel_s   = a_in;
    b_sel_s   = '0;
    cin_sel_s = 1'b0;
    case (op_code)
      OP_PASS: begin a_sel_s = a_in; b_sel_s = '0;               cin_sel_s = 1'b0;     end
      OP_ADD:  begin a_sel_s = a_in; b_sel_s = b_in;             cin_sel_s = 1'b0;     end
      OP_ADC:  begin a_sel_s = a_in; b_sel_s = b_in;             cin_sel_s = carry_in; end
      OP_SUB:  begin a_sel_s = a_in; b_sel_s = ~b_in;            cin_sel_s = 1'b1;     end
      OP_SBB:  begin a_sel_s = a_in; b_sel_s = ~b_in;            cin_sel_s = carry_in; end
      OP_INC:  begin a_sel_s = a_in; b_sel_s = '0;               cin_sel_s = 1'b1;     end
      OP_DEC:  begin a_sel_s = a_in; b_sel_s = {DATA_W{1'b1}};   cin_sel_s = 1'b0;     end
      OP_NEG:  begin a_sel_s = '0;   b_sel_s = ~b_in;            cin_sel_s = 1'b1;     end
      default: begin a_sel_s = a_in; b_sel_s = '0;               cin_sel_s = 1'b0;     end
    endcase
  end

  // Shared slice adder and the result shift-in path (new slice enters at the top).
  always_comb begin
    slice_sum_s = {1'b0, a_sh_r[SLICE_W-1:0]}
                + {1'b0, b_sh_r[SLICE_W-1:0]}
                + {{SLICE_W{1'b0}}, carry_r};
    slice_ext_s = '0;
    slice_ext_s[SLICE_W-1:0] = slice_sum_s[SLICE_W-1:0];
    result_next_s = (result_r >> SLICE_W) | (slice_ext_s << (DATA_W - SLICE_W));
    last_slice_s  = (cnt_r == CNT_W'(NSLICE - 1));
  end

  // Control FSM, operand shift registers, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      carry_r     <= 1'b0;
      any_nz_r    <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r  <= ST_BUSY;
            cnt_r    <= '0;
            a_sh_r   <= a_sel_s;
            b_sh_r   <= b_sel_s;
            carry_r  <= cin_sel_s;
            any_nz_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          a_sh_r   <= a_sh_r >> SLICE_W;
          b_sh_r   <= b_sh_r >> SLICE_W;
          carry_r  <= slice_sum_s[SLICE_W];
          result_r <= result_next_s;
          any_nz_r <= any_nz_r | (|slice_sum_s[SLICE_W-1:0]);
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_slice_s) begin
            // On the last slice the operand registers hold the top slice,
            // so their bit SLICE_W-1 is the operand sign bit.
            state_r     <= ST_DONE;
            carry_out_r <= slice_sum_s[SLICE_W];
            overflow_r  <= (a_sh_r[SLICE_W-1] == b_sh_r[SLICE_W-1]) &&
                           (slice_sum_s[SLICE_W-1] != a_sh_r[SLICE_W-1]);
            zero_r      <= ~(any_nz_r | (|slice_sum_s[SLICE_W-1:0]));
            negative_r  <= slice_sum_s[SLICE_W-1];
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);
  assign result_out = result_r;
  assign carry_out  = carry_out_r;
  assign overflow   = overflow_r;
  assign zero       = zero_r;
  assign negative   = negative_r;

endmodule

// File: tb/tb_arithmetic_unit_serial.sv
// Self-checking bench for arithmetic_unit_serial (DATA_W=32, SLICE_W=8).
// Expected values come from a whole-word arithmetic model of the op map.
module tb_arithmetic_unit_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_code;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        negative;

  int n_checks = 0;
  int n_fail   = 0;

  arithmetic_unit_serial #(.DATA_W(32), .SLICE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_code    (op_code),
    .a_in       (a_in),
    .b_in       (b_in),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .zero       (zero),
    .negative   (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {carry, overflow, zero, negative, result}.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    logic [31:0] ap, bp;
    logic        c0;
    logic [32:0] sum;
    logic        v;
    case (op)
      3'd0: begin ap = a;     bp = 32'd0;          c0 = 1'b0; end
      3'd1: begin ap = a;     bp = b;              c0 = 1'b0; end
      3'd2: begin ap = a;     bp = b;              c0 = ci;   end
      3'd3: begin ap = a;     bp = ~b;             c0 = 1'b1; end
      3'd4: begin ap = a;     bp = ~b;             c0 = ci;   end
      3'd5: begin ap = a;     bp = 32'd0;          c0 = 1'b1; end
      3'd6: begin ap = a;     bp = 32'hFFFF_FFFF;  c0 = 1'b0; end
      default: begin ap = 32'd0; bp = ~b;          c0 = 1'b1; end
    endcase
    sum = {1'b0, ap} + {1'b0, bp} + {32'd0, c0};
    v   = (ap[31] == bp[31]) && (sum[31] != ap[31]);
    return {sum[32], v, (sum[31:0] == 32'd0), sum[31], sum[31:0]};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {carry_out, overflow, zero, negative};
  endfunction

  // Present one request and complete the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_val("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op_code  = op;
    a_in     = a;
    b_in     = b;
    carry_in = ci;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge: wait for out_valid, check latency and values.
  task automatic wait_and_check(input string tag, input logic [35:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd4);
    check_val({tag, "_result"}, 64'(result_out), 64'(exp[31:0]));
    check_val({tag, "_flags"}, 64'(dut_flags()), 64'(exp[35:32]));
    check_val({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
  endtask

  // Complete the output handshake and confirm the result holds in IDLE.
  task automatic handshake(input string tag, input logic [35:0] exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_post_hs"}, 64'({out_valid, in_ready, result_out, dut_flags()}),
              64'({1'b0, 1'b1, exp[31:0], exp[35:32]}));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ci, output logic [35:0] exp);
    exp = model(op, a, b, ci);
    start_op(op, a, b, ci);
    wait_and_check(tag, exp);
    handshake(tag, exp);
  endtask

  logic [35:0] e, e1, e2;
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  logic        seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_code = 3'd0; a_in = 32'd0; b_in = 32'd0; carry_in = 1'b0;
    #12;
    check_val("reset_state", 64'({in_ready, out_valid, result_out, dut_flags()}),
              64'({1'b1, 1'b0, 32'd0, 4'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("add_wrap", 3'd1, 32'hFFFF_FFFF, 32'h1, 1'b0, e);
    check_val("add_wrap_exact", 64'({result_out, dut_flags()}), 64'({32'h0, 4'b1010}));
    run_op("sub_ovf", 3'd3, 32'h8000_0000, 32'h1, 1'b0, e);
    check_val("sub_ovf_exact", 64'({result_out, dut_flags()}), 64'({32'h7FFF_FFFF, 4'b1100}));

    // 64-bit add chain: low word then high word with carry forwarded.
    run_op("chain_add_lo", 3'd1, 32'hFFFF_FFFF, 32'h1, 1'b0, e1);
    run_op("chain_adc_hi", 3'd2, 32'h1, 32'h0, e1[35], e2);
    check_val("chain_add_64", {e2[31:0], e1[31:0]}, 64'h0000_0002_0000_0000);
    // 64-bit subtract chain: 0x1_0000_0000 - 1.
    run_op("chain_sub_lo", 3'd3, 32'h0, 32'h1, 1'b0, e1);
    run_op("chain_sbb_hi", 3'd4, 32'h1, 32'h0, e1[35], e2);
    check_val("chain_sub_64", {e2[31:0], e1[31:0]}, 64'h0000_0000_FFFF_FFFF);

    run_op("dec_zero", 3'd6, 32'h0, 32'h0, 1'b0, e);
    check_val("dec_zero_exact", 64'({result_out, carry_out}), 64'({32'hFFFF_FFFF, 1'b0}));
    run_op("inc_ovf", 3'd5, 32'h7FFF_FFFF, 32'h0, 1'b0, e);
    check_val("inc_ovf_exact", 64'({result_out, overflow}), 64'({32'h8000_0000, 1'b1}));
    run_op("neg_5", 3'd7, 32'h0, 32'h5, 1'b0, e);
    check_val("neg_5_exact", 64'(result_out), 64'hFFFF_FFFB);
    run_op("neg_min", 3'd7, 32'h0, 32'h8000_0000, 1'b0, e);
    check_val("neg_min_exact", 64'({result_out, overflow}), 64'({32'h8000_0000, 1'b1}));
    run_op("pass", 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, e);
    check_val("pass_exact", 64'({result_out, zero}), 64'({32'h1234_5678, 1'b0}));

    // Backpressure: result held for 5 cycles while a second request waits.
    e1 = model(3'd3, 32'h0000_1000, 32'h0000_2000, 1'b0);
    start_op(3'd3, 32'h0000_1000, 32'h0000_2000, 1'b0);
    wait_and_check("bp_first", e1);
    e2 = model(3'd2, 32'hABCD_0001, 32'h1111_FFFF, 1'b1);
    in_valid = 1'b1; op_code = 3'd2; a_in = 32'hABCD_0001; b_in = 32'h1111_FFFF; carry_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp_hold", 64'({out_valid, in_ready, result_out, dut_flags()}),
                64'({1'b1, 1'b0, e1[31:0], e1[35:32]}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("bp_back_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    @(posedge clk);   // second request accepted here
    #1;
    in_valid = 1'b0;
    wait_and_check("bp_second", e2);
    handshake("bp_second", e2);

    // Reset during the second BUSY slice aborts the operation.
    start_op(3'd1, 32'h0101_0101, 32'h0202_0202, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_reset_vals", 64'({in_ready, out_valid, result_out, dut_flags()}),
              64'({1'b1, 1'b0, 32'd0, 4'd0}));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("abort_no_valid", 64'(seen), 64'd0);
    run_op("after_abort", 3'd1, 32'd2, 32'd3, 1'b0, e);
    check_val("after_abort_exact", 64'(result_out), 64'd5);

    // Randomized ops with a mix of corner operands.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h7FFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
